// File: rtl/array_binop_stream.sv
// Streams element-wise add/sub/max/min over two read-only memories into a third.
// Ports: clk, rst_n, tstart, op -> v0/v1 read ports, v2 write port, busy, done.
module array_binop_stream #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 7,
    parameter int LEN    = 128,
    parameter int RD_LAT = 1,
    parameter int SAT    = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tstart,
    input  logic [1:0]        op,
    output logic [ADDR_W-1:0] v0_addr,
    output logic              v0_rd_en,
    input  logic [DATA_W-1:0] v0_rd_data,
    output logic [ADDR_W-1:0] v1_addr,
    output logic              v1_rd_en,
    input  logic [DATA_W-1:0] v1_rd_data,
    output logic [ADDR_W-1:0] v2_addr,
    output logic              v2_wr_en,
    output logic [DATA_W-1:0] v2_wr_data,
    output logic              busy,
    output logic              done
);

    localparam int CW = $clog2(LEN + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        FINISH
    } state_t;

    state_t state, state_nx;

    logic [CW-1:0]     cnt;
    logic [1:0]        op_q;
    logic              start;
    logic              issue;
    logic              last_issue;
    logic              wr_last;
    logic [RD_LAT-1:0] tag_vld;
    logic [RD_LAT-1:0] tag_last;
    logic [ADDR_W-1:0] tag_idx [RD_LAT];
    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   diff;
    logic [DATA_W-1:0] res;

    // FINISH behaves as IDLE for acceptance, so back-to-back runs have no bubble.
    assign start      = tstart && (state == IDLE || state == FINISH);
    assign issue      = (state == ISSUE);
    assign last_issue = issue && (cnt == CW'(LEN - 1));

    assign busy     = (state == ISSUE) || (state == DRAIN);
    assign done     = (state == FINISH);
    assign v0_rd_en = issue;
    assign v1_rd_en = issue;
    // The counter stops on the last index, so addresses hold after ISSUE.
    assign v0_addr  = ADDR_W'(cnt);
    assign v1_addr  = ADDR_W'(cnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = ISSUE;
            ISSUE:   if (last_issue) state_nx = DRAIN;
            DRAIN:   if (v2_wr_en && wr_last) state_nx = FINISH;
            FINISH:  state_nx = start ? ISSUE : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            op_q <= '0;
        end else if (start) begin
            cnt  <= '0;
            op_q <= op;
        end else if (issue && !last_issue) begin
            cnt  <= cnt + CW'(1);
        end
    end

    // Each issued read travels with its index; the tap at RD_LAT-1 marks
    // the cycle in which the memory data for that index is valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld  <= '0;
            tag_last <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                tag_idx[k] <= '0;
            end
        end else begin
            tag_vld[0]  <= issue;
            tag_last[0] <= last_issue;
            tag_idx[0]  <= v0_addr;
            for (int k = 1; k < RD_LAT; k++) begin
                tag_vld[k]  <= tag_vld[k-1];
                tag_last[k] <= tag_last[k-1];
                tag_idx[k]  <= tag_idx[k-1];
            end
        end
    end

    always_comb begin
        sum  = {1'b0, v0_rd_data} + {1'b0, v1_rd_data};
        diff = {1'b0, v0_rd_data} - {1'b0, v1_rd_data};
        res  = '0;
        unique case (op_q)
            2'd0: res = (SAT != 0 && sum[DATA_W]) ? '1 : sum[DATA_W-1:0];
            2'd1: res = (SAT != 0 && diff[DATA_W]) ? '0 : diff[DATA_W-1:0];
            2'd2: res = (v0_rd_data >= v1_rd_data) ? v0_rd_data : v1_rd_data;
            2'd3: res = (v0_rd_data <= v1_rd_data) ? v0_rd_data : v1_rd_data;
            default: res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_wr_en   <= 1'b0;
            v2_addr    <= '0;
            v2_wr_data <= '0;
            wr_last    <= 1'b0;
        end else if (tag_vld[RD_LAT-1]) begin
            v2_wr_en   <= 1'b1;
            v2_addr    <= tag_idx[RD_LAT-1];
            v2_wr_data <= res;
            wr_last    <= tag_last[RD_LAT-1];
        end else begin
            v2_wr_en   <= 1'b0;
            wr_last    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_array_binop_stream.sv
// Randomized and directed bench for array_binop_stream.
// Instance a: defaults (SAT=0, RD_LAT=1, LEN=128); instance b: SAT=1, RD_LAT=3, LEN=4.
module tb_array_binop_stream;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        a_tstart, b_tstart;
    logic [1:0]  a_op, b_op;
    logic [6:0]  a_v0_addr, a_v1_addr, a_v2_addr;
    logic [1:0]  b_v0_addr, b_v1_addr, b_v2_addr;
    logic        a_v0_rd_en, a_v1_rd_en, a_v2_wr_en, a_busy, a_done;
    logic        b_v0_rd_en, b_v1_rd_en, b_v2_wr_en, b_busy, b_done;
    logic [31:0] a_v0_rd_data, a_v1_rd_data, a_v2_wr_data;
    logic [31:0] b_v0_rd_data, b_v1_rd_data, b_v2_wr_data;

    array_binop_stream u_a (
        .clk(clk), .rst_n(rst_n), .tstart(a_tstart), .op(a_op),
        .v0_addr(a_v0_addr), .v0_rd_en(a_v0_rd_en), .v0_rd_data(a_v0_rd_data),
        .v1_addr(a_v1_addr), .v1_rd_en(a_v1_rd_en), .v1_rd_data(a_v1_rd_data),
        .v2_addr(a_v2_addr), .v2_wr_en(a_v2_wr_en), .v2_wr_data(a_v2_wr_data),
        .busy(a_busy), .done(a_done)
    );

    array_binop_stream #(
        .DATA_W(32), .ADDR_W(2), .LEN(4), .RD_LAT(3), .SAT(1)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .tstart(b_tstart), .op(b_op),
        .v0_addr(b_v0_addr), .v0_rd_en(b_v0_rd_en), .v0_rd_data(b_v0_rd_data),
        .v1_addr(b_v1_addr), .v1_rd_en(b_v1_rd_en), .v1_rd_data(b_v1_rd_data),
        .v2_addr(b_v2_addr), .v2_wr_en(b_v2_wr_en), .v2_wr_data(b_v2_wr_data),
        .busy(b_busy), .done(b_done)
    );

    // Source memories and read-latency models; data is X outside the window.
    logic [31:0] m0 [2][128];
    logic [31:0] m1 [2][128];
    logic [31:0] pa0 [4], pb0 [4], pa1 [4], pb1 [4];
    logic [3:0]  va0 = '0, vb0 = '0, va1 = '0, vb1 = '0;

    always @(posedge clk) begin
        for (int k = 3; k > 0; k--) begin
            pa0[k] <= pa0[k-1];
            pb0[k] <= pb0[k-1];
            pa1[k] <= pa1[k-1];
            pb1[k] <= pb1[k-1];
        end
        pa0[0] <= m0[0][a_v0_addr];
        pb0[0] <= m1[0][a_v1_addr];
        pa1[0] <= m0[1][b_v0_addr];
        pb1[0] <= m1[1][b_v1_addr];
        va0 <= {va0[2:0], a_v0_rd_en};
        vb0 <= {vb0[2:0], a_v1_rd_en};
        va1 <= {va1[2:0], b_v0_rd_en};
        vb1 <= {vb1[2:0], b_v1_rd_en};
    end

    assign a_v0_rd_data = va0[0] ? pa0[0] : 'x;
    assign a_v1_rd_data = vb0[0] ? pb0[0] : 'x;
    assign b_v0_rd_data = va1[2] ? pa1[2] : 'x;
    assign b_v1_rd_data = vb1[2] ? pb1[2] : 'x;

    // Event log shared by both instances; only one runs at a time.
    typedef struct {
        int          cyc;
        int          addr;
        int          addr2;
        logic [31:0] data;
    } ev_t;

    ev_t rq[$];
    ev_t wq[$];
    int  dq[$];
    int  bcnt;

    always @(negedge clk) begin
        if (a_v0_rd_en || a_v1_rd_en)
            rq.push_back('{cyc, int'(a_v0_addr), int'(a_v1_addr), 32'h0});
        if (b_v0_rd_en || b_v1_rd_en)
            rq.push_back('{cyc, int'(b_v0_addr), int'(b_v1_addr), 32'h0});
        if (a_v2_wr_en) wq.push_back('{cyc, int'(a_v2_addr), 0, a_v2_wr_data});
        if (b_v2_wr_en) wq.push_back('{cyc, int'(b_v2_addr), 0, b_v2_wr_data});
        if (a_done || b_done) dq.push_back(cyc);
        if (a_busy || b_busy) bcnt++;
    end

    int passed = 0;
    int failed = 0;
    int total  = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_op(input logic [1:0] o, input int sat,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        longint unsigned x, y, r;
        x = a;
        y = b;
        case (o)
            2'd0: begin
                r = x + y;
                if (r > 64'hFFFF_FFFF) r = sat ? 64'hFFFF_FFFF : r - 64'h1_0000_0000;
            end
            2'd1: begin
                if (x >= y) r = x - y;
                else r = sat ? 64'h0 : x + 64'h1_0000_0000 - y;
            end
            2'd2: r = (x >= y) ? x : y;
            default: r = (x <= y) ? x : y;
        endcase
        return r[31:0];
    endfunction

    function automatic int len_of(input int u);
        return (u == 0) ? 128 : 4;
    endfunction

    function automatic int lat_of(input int u);
        return (u == 0) ? 1 : 3;
    endfunction

    task automatic clear_log();
        rq.delete();
        wq.delete();
        dq.delete();
        bcnt = 0;
    endtask

    task automatic pulse(input int u, input logic [1:0] o, output int s);
        s = cyc;
        if (u == 0) begin
            a_tstart = 1'b1;
            a_op     = o;
        end else begin
            b_tstart = 1'b1;
            b_op     = o;
        end
        @(negedge clk);
        a_tstart = 1'b0;
        b_tstart = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int k = 0; k < budget && dq.size() == 0; k++) @(negedge clk);
        repeat (2) @(negedge clk);
    endtask

    // Compares one run's read issue, writes and done against the timing rules.
    task automatic check_run(input int u, input int s, input logic [1:0] o,
                             input bit solo);
        int  len, lat, sat, d;
        ev_t e;
        len = len_of(u);
        lat = lat_of(u);
        sat = (u == 0) ? 0 : 1;
        if (solo) begin
            chk("n_reads", rq.size(), len);
            chk("n_writes", wq.size(), len);
            chk("n_done", dq.size(), 1);
            chk("busy_cycles", bcnt, len + lat + 1);
        end
        for (int k = 0; k < len; k++) begin
            e = (rq.size() > 0) ? rq.pop_front() : '{-1, -1, -1, 32'h0};
            chk("rd_cycle", e.cyc, s + 1 + k);
            chk("rd_addr0", e.addr, k);
            chk("rd_addr1", e.addr2, k);
        end
        for (int k = 0; k < len; k++) begin
            e = (wq.size() > 0) ? wq.pop_front() : '{-1, -1, -1, 32'h0};
            chk("wr_cycle", e.cyc, s + 2 + k + lat);
            chk("wr_addr", e.addr, k);
            chk("wr_data", e.data, ref_op(o, sat, m0[u][k], m1[u][k]));
        end
        d = (dq.size() > 0) ? dq.pop_front() : -1;
        chk("done_cycle", d, s + 2 + len + lat);
    endtask

    task automatic run(input int u, input logic [1:0] o);
        int s;
        clear_log();
        pulse(u, o, s);
        wait_done(len_of(u) + lat_of(u) + 10);
        check_run(u, s, o, 1'b1);
    endtask

    task automatic fill_rand(input int u);
        for (int i = 0; i < 128; i++) begin
            m0[u][i] = $urandom;
            m1[u][i] = $urandom;
        end
    endtask

    task automatic fill_const(input int u, input logic [31:0] x,
                              input logic [31:0] y);
        for (int i = 0; i < 128; i++) begin
            m0[u][i] = x;
            m1[u][i] = y;
        end
    endtask

    initial begin
        int s1, s2, s3;
        rst_n    = 1'b0;
        a_tstart = 1'b0;
        b_tstart = 1'b0;
        a_op     = 2'd0;
        b_op     = 2'd0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {a_busy, b_busy}, 0);
        chk("rst_done", {a_done, b_done}, 0);
        chk("rst_rd_en", {a_v0_rd_en, a_v1_rd_en, b_v0_rd_en, b_v1_rd_en}, 0);
        chk("rst_wr_en", {a_v2_wr_en, b_v2_wr_en}, 0);
        chk("rst_addr", {a_v0_addr, a_v1_addr, a_v2_addr, b_v2_addr}, 0);
        chk("rst_wdata", {a_v2_wr_data, b_v2_wr_data}, 0);
        rst_n = 1'b1;

        // Default config, add, start pulse in cycle 9.
        for (int i = 0; i < 128; i++) begin
            m0[0][i] = 32'(5 + i);
            m1[0][i] = 32'(100 + i);
        end
        while (cyc < 9) @(negedge clk);
        run(0, 2'd0);

        // Sub and add at the wrap / saturation boundaries.
        fill_const(0, 32'd5, 32'd100);
        run(0, 2'd1);
        fill_const(1, 32'd5, 32'd100);
        run(1, 2'd1);
        fill_const(0, 32'hFFFF_FFF0, 32'h20);
        run(0, 2'd0);
        fill_const(1, 32'hFFFF_FFF0, 32'h20);
        run(1, 2'd0);

        // Max / min across the equality point.
        for (int i = 0; i < 128; i++) begin
            m0[0][i] = 32'(i);
            m1[0][i] = 32'd63;
        end
        run(0, 2'd2);
        run(0, 2'd3);
        for (int i = 0; i < 4; i++) begin
            m0[1][i] = 32'(i + 1);
            m1[1][i] = 32'd2;
        end
        run(1, 2'd2);
        run(1, 2'd3);

        // Random operands and operations.
        for (int r = 0; r < 4; r++) begin
            for (int u = 0; u < 2; u++) begin
                fill_rand(u);
                run(u, 2'($urandom_range(3)));
            end
        end

        // tstart during busy is ignored; tstart in done cycle starts a run.
        fill_rand(0);
        clear_log();
        pulse(0, 2'd2, s1);
        while (cyc < s1 + 5) @(negedge clk);
        a_tstart = 1'b1;
        a_op     = 2'd3;
        @(negedge clk);
        a_tstart = 1'b0;
        for (int k = 0; k < 200 && !a_done; k++) @(negedge clk);
        chk("done_seen", a_done, 1'b1);
        pulse(0, 2'd1, s2);
        bcnt = 0;
        check_run(0, s1, 2'd2, 1'b0);
        wait_done(150);
        check_run(0, s2, 2'd1, 1'b1);

        // Reset mid-ISSUE aborts the run; a fresh run is complete.
        fill_rand(0);
        clear_log();
        pulse(0, 2'd0, s3);
        while (cyc < s3 + 41) @(negedge clk);
        chk("pre_rst_addr", a_v0_addr, 40);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", a_busy, 0);
        chk("arst_rd_en", {a_v0_rd_en, a_v1_rd_en}, 0);
        chk("arst_wr_en", a_v2_wr_en, 0);
        chk("arst_addr", {a_v0_addr, a_v1_addr, a_v2_addr}, 0);
        chk("arst_wdata", a_v2_wr_data, 0);
        clear_log();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("post_rst_writes", wq.size(), 0);
        chk("post_rst_reads", rq.size(), 0);
        chk("post_rst_done", dq.size(), 0);
        fill_rand(0);
        run(0, 2'($urandom_range(3)));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
